// File: rtl/pc_seq.sv
// Program-counter sequencer: stall/branch/exception redirect, saved EPC,
// circular return-address stack and a boot/exception bubble FSM.
module pc_seq #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(32'h0000_0000),
   parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h0000_0004),
   parameter int               INC       = 4,
   parameter int               RAS_DEPTH = 4
) (
   input  logic                           i_clk_w,
   input  logic                           i_rst_n_w,
   input  logic                           i_stall_w,
   input  logic                           i_br_taken_w,
   input  logic [WIDTH-1:0]               i_br_target_w,
   input  logic                           i_exc_w,
   input  logic                           i_link_w,
   input  logic                           i_ret_w,
   output logic [WIDTH-1:0]               o_pc_w,
   output logic [WIDTH-1:0]               o_pc_plus_w,
   output logic                           o_valid_w,
   output logic [WIDTH-1:0]               o_epc_w,
   output logic [$clog2(RAS_DEPTH+1)-1:0] o_ras_cnt_w,
   output logic                           o_ras_uflow_w
);

   localparam int               PTR_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int               CNT_W   = $clog2(RAS_DEPTH + 1);
   localparam logic [WIDTH-1:0] INC_V   = WIDTH'(INC);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_EXC  = 2'd2
   } state_t;

   state_t           state_r, state_s;
   logic [WIDTH-1:0] pc_r, pc_s;
   logic [WIDTH-1:0] epc_r, epc_s;
   logic [WIDTH-1:0] pc_plus_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic [PTR_W-1:0] sp_r, sp_s;
   logic [PTR_W-1:0] top_idx_s;
   logic [PTR_W-1:0] ras_wa_s;
   logic             ras_we_s;
   logic             uflow_r, uflow_s;
   logic             valid_r;
   logic [WIDTH-1:0] ras_r [RAS_DEPTH];

   // sp_r is the next free slot; the top of stack sits one below it (circular)
   assign pc_plus_s = pc_r + INC_V;
   assign top_idx_s = sp_r - PTR_W'(1);

   // Next-state, next-PC and RAS control
   always_comb begin
      state_s  = state_r;
      pc_s     = pc_r;
      epc_s    = epc_r;
      cnt_s    = cnt_r;
      sp_s     = sp_r;
      uflow_s  = 1'b0;
      ras_we_s = 1'b0;
      ras_wa_s = sp_r;
      case (state_r)
         ST_BOOT: state_s = ST_RUN;
         ST_EXC: begin
            if (i_exc_w) state_s = ST_EXC;
            else         state_s = ST_RUN;
         end
         ST_RUN: begin
            if (i_exc_w) begin
               pc_s    = EXC_VEC;
               epc_s   = pc_r;
               state_s = ST_EXC;
            end else if (i_br_taken_w) begin
               pc_s = i_br_target_w;
            end else if (i_stall_w) begin
               pc_s = pc_r;
            end else begin
               if (i_ret_w && (cnt_r != CNT_W'(0))) pc_s = ras_r[top_idx_s];
               else                                 pc_s = pc_plus_s;
               uflow_s = i_ret_w && (cnt_r == CNT_W'(0));
               // Link+ret on a non-empty stack swaps the top in place
               if (i_link_w && i_ret_w && (cnt_r != CNT_W'(0))) begin
                  ras_we_s = 1'b1;
                  ras_wa_s = top_idx_s;
               end else if (i_link_w) begin
                  ras_we_s = 1'b1;
                  sp_s     = sp_r + PTR_W'(1);
                  if (cnt_r != CNT_MAX) cnt_s = cnt_r + CNT_W'(1);
                  else                  cnt_s = cnt_r;
               end else if (i_ret_w && (cnt_r != CNT_W'(0))) begin
                  sp_s  = sp_r - PTR_W'(1);
                  cnt_s = cnt_r - CNT_W'(1);
               end else begin
                  sp_s = sp_r;
               end
            end
         end
         default: state_s = ST_BOOT;
      endcase
   end

   // Control and PC registers
   always_ff @(posedge i_clk_w or negedge i_rst_n_w) begin
      if (!i_rst_n_w) begin
         state_r <= ST_BOOT;
         pc_r    <= RESET_VEC;
         epc_r   <= '0;
         cnt_r   <= '0;
         sp_r    <= '0;
         uflow_r <= 1'b0;
         valid_r <= 1'b0;
      end else begin
         state_r <= state_s;
         pc_r    <= pc_s;
         epc_r   <= epc_s;
         cnt_r   <= cnt_s;
         sp_r    <= sp_s;
         uflow_r <= uflow_s;
         valid_r <= (state_s == ST_RUN);
      end
   end

   // Return-address stack storage, cleared on reset
   always_ff @(posedge i_clk_w or negedge i_rst_n_w) begin
      if (!i_rst_n_w) begin
         for (int i = 0; i < RAS_DEPTH; i++) ras_r[i] <= '0;
      end else if (ras_we_s) begin
         ras_r[ras_wa_s] <= pc_plus_s;
      end
   end

   assign o_pc_w        = pc_r;
   assign o_pc_plus_w   = pc_plus_s;
   assign o_valid_w     = valid_r;
   assign o_epc_w       = epc_r;
   assign o_ras_cnt_w   = cnt_r;
   assign o_ras_uflow_w = uflow_r;

endmodule

// File: tb/tb_pc_seq.sv
// Scoreboard bench for pc_seq: a 32-bit default instance and a 16-bit
// instance with non-zero reset/exception vectors.
module tb_pc_seq;

   localparam logic [4:0] N = 5'b00000;
   localparam logic [4:0] S = 5'b10000;
   localparam logic [4:0] B = 5'b01000;
   localparam logic [4:0] E = 5'b00100;
   localparam logic [4:0] L = 5'b00010;
   localparam logic [4:0] R = 5'b00001;

   typedef struct {
      bit          u16;
      int          idx;
      logic [31:0] pc;
      logic        valid;
      logic [31:0] epc;
      logic [2:0]  cnt;
      logic        uf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n32, stall32, br32, exc32, link32, ret32;
   logic [31:0] tgt32, pc32, pcp32, epc32;
   logic        valid32, uf32;
   logic [2:0]  cnt32;
   logic        rst_n16, stall16, br16, exc16, link16, ret16;
   logic [15:0] tgt16, pc16, pcp16, epc16;
   logic        valid16, uf16;
   logic [2:0]  cnt16;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_step = 0;

   always #5 clk = ~clk;

   pc_seq u_dut32 (
      .i_clk_w(clk), .i_rst_n_w(rst_n32), .i_stall_w(stall32),
      .i_br_taken_w(br32), .i_br_target_w(tgt32), .i_exc_w(exc32),
      .i_link_w(link32), .i_ret_w(ret32), .o_pc_w(pc32), .o_pc_plus_w(pcp32),
      .o_valid_w(valid32), .o_epc_w(epc32), .o_ras_cnt_w(cnt32),
      .o_ras_uflow_w(uf32)
   );

   pc_seq #(.WIDTH(16), .RESET_VEC(16'h0100), .EXC_VEC(16'h0010)) u_dut16 (
      .i_clk_w(clk), .i_rst_n_w(rst_n16), .i_stall_w(stall16),
      .i_br_taken_w(br16), .i_br_target_w(tgt16), .i_exc_w(exc16),
      .i_link_w(link16), .i_ret_w(ret16), .o_pc_w(pc16), .o_pc_plus_w(pcp16),
      .o_valid_w(valid16), .o_epc_w(epc16), .o_ras_cnt_w(cnt16),
      .o_ras_uflow_w(uf16)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of requests, queue the expectation, then compare after the edge
   task automatic step(input bit u16, input logic [4:0] req, input logic [31:0] tgt,
                       input logic [31:0] e_pc, input logic e_v, input logic [31:0] e_epc,
                       input logic [2:0] e_cnt, input logic e_uf);
      exp_t e;
      n_step++;
      if (u16) begin
         {stall16, br16, exc16, link16, ret16} = req;
         tgt16 = tgt[15:0];
      end else begin
         {stall32, br32, exc32, link32, ret32} = req;
         tgt32 = tgt;
      end
      sb_q.push_back('{u16, n_step, e_pc, e_v, e_epc, e_cnt, e_uf});
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check_eq("sb_empty", 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         if (e.u16) begin
            check_eq($sformatf("w16 pc@%0d", e.idx), {16'h0000, pc16}, e.pc);
            check_eq($sformatf("w16 pcplus@%0d", e.idx), {16'h0000, pcp16}, (e.pc + 32'd4) & 32'h0000_FFFF);
            check_eq($sformatf("w16 valid@%0d", e.idx), {31'd0, valid16}, {31'd0, e.valid});
            check_eq($sformatf("w16 epc@%0d", e.idx), {16'h0000, epc16}, e.epc);
            check_eq($sformatf("w16 cnt@%0d", e.idx), {29'd0, cnt16}, {29'd0, e.cnt});
            check_eq($sformatf("w16 uflow@%0d", e.idx), {31'd0, uf16}, {31'd0, e.uf});
         end else begin
            check_eq($sformatf("pc@%0d", e.idx), pc32, e.pc);
            check_eq($sformatf("pcplus@%0d", e.idx), pcp32, e.pc + 32'd4);
            check_eq($sformatf("valid@%0d", e.idx), {31'd0, valid32}, {31'd0, e.valid});
            check_eq($sformatf("epc@%0d", e.idx), epc32, e.epc);
            check_eq($sformatf("cnt@%0d", e.idx), {29'd0, cnt32}, {29'd0, e.cnt});
            check_eq($sformatf("uflow@%0d", e.idx), {31'd0, uf32}, {31'd0, e.uf});
         end
      end
   endtask

   initial begin
      rst_n32 = 1'b0; rst_n16 = 1'b0;
      {stall32, br32, exc32, link32, ret32} = 5'b00000; tgt32 = 32'h0;
      {stall16, br16, exc16, link16, ret16} = 5'b00000; tgt16 = 16'h0;
      #12;
      check_eq("rst pc", pc32, 32'h0);
      check_eq("rst valid", {31'd0, valid32}, 32'd0);
      check_eq("rst epc", epc32, 32'h0);
      check_eq("rst cnt", {29'd0, cnt32}, 32'd0);
      check_eq("rst uflow", {31'd0, uf32}, 32'd0);
      check_eq("w16 rst pc", {16'h0000, pc16}, 32'h0100);
      #1;
      rst_n32 = 1'b1; rst_n16 = 1'b1;
      check_eq("boot valid", {31'd0, valid32}, 32'd0);

      // Boot bubble then sequential fetch
      step(0, N, 32'h0,   32'h00, 1, 32'h0,  3'd0, 0);
      step(0, N, 32'h0,   32'h04, 1, 32'h0,  3'd0, 0);
      step(0, N, 32'h0,   32'h08, 1, 32'h0,  3'd0, 0);
      step(0, N, 32'h0,   32'h0C, 1, 32'h0,  3'd0, 0);
      step(0, N, 32'h0,   32'h10, 1, 32'h0,  3'd0, 0);
      // Stall with branch overriding on the second stall cycle
      step(0, S,     32'h0,   32'h010, 1, 32'h0, 3'd0, 0);
      step(0, S | B, 32'h100, 32'h100, 1, 32'h0, 3'd0, 0);
      step(0, S,     32'h0,   32'h100, 1, 32'h0, 3'd0, 0);
      step(0, N,     32'h0,   32'h104, 1, 32'h0, 3'd0, 0);
      // Exception beats branch; then re-entry while already in EXC
      step(0, B,     32'h20,  32'h20, 1, 32'h00, 3'd0, 0);
      step(0, E | B, 32'h300, 32'h04, 0, 32'h20, 3'd0, 0);
      step(0, N,     32'h0,   32'h04, 1, 32'h20, 3'd0, 0);
      step(0, N,     32'h0,   32'h08, 1, 32'h20, 3'd0, 0);
      step(0, E,     32'h0,   32'h04, 0, 32'h08, 3'd0, 0);
      step(0, E,     32'h0,   32'h04, 0, 32'h08, 3'd0, 0);
      step(0, N,     32'h0,   32'h04, 1, 32'h08, 3'd0, 0);
      // Five links into a 4-deep stack
      step(0, B, 32'h40, 32'h40, 1, 32'h08, 3'd0, 0);
      step(0, L, 32'h0,  32'h44, 1, 32'h08, 3'd1, 0);
      step(0, B, 32'h80, 32'h80, 1, 32'h08, 3'd1, 0);
      step(0, L, 32'h0,  32'h84, 1, 32'h08, 3'd2, 0);
      step(0, B, 32'h90, 32'h90, 1, 32'h08, 3'd2, 0);
      step(0, L, 32'h0,  32'h94, 1, 32'h08, 3'd3, 0);
      step(0, B, 32'hA0, 32'hA0, 1, 32'h08, 3'd3, 0);
      step(0, L, 32'h0,  32'hA4, 1, 32'h08, 3'd4, 0);
      step(0, B, 32'hB0, 32'hB0, 1, 32'h08, 3'd4, 0);
      step(0, L, 32'h0,  32'hB4, 1, 32'h08, 3'd4, 0);
      // Returns: stall holds, four pops, then underflow
      step(0, S | R, 32'h0, 32'hB4, 1, 32'h08, 3'd4, 0);
      step(0, R,     32'h0, 32'hB4, 1, 32'h08, 3'd3, 0);
      step(0, R,     32'h0, 32'hA4, 1, 32'h08, 3'd2, 0);
      step(0, R,     32'h0, 32'h94, 1, 32'h08, 3'd1, 0);
      step(0, R,     32'h0, 32'h84, 1, 32'h08, 3'd0, 0);
      step(0, R,     32'h0, 32'h88, 1, 32'h08, 3'd0, 1);
      step(0, N,     32'h0, 32'h8C, 1, 32'h08, 3'd0, 0);
      // Link+ret swap on a non-empty stack, and on an empty one
      step(0, B,     32'h1FC, 32'h1FC, 1, 32'h08, 3'd0, 0);
      step(0, L,     32'h0,   32'h200, 1, 32'h08, 3'd1, 0);
      step(0, B | L, 32'h300, 32'h300, 1, 32'h08, 3'd1, 0);
      step(0, L | R, 32'h0,   32'h200, 1, 32'h08, 3'd1, 0);
      step(0, R,     32'h0,   32'h304, 1, 32'h08, 3'd0, 0);
      step(0, L | R, 32'h0,   32'h308, 1, 32'h08, 3'd1, 1);
      step(0, R,     32'h0,   32'h308, 1, 32'h08, 3'd0, 0);
      step(0, L,     32'h0,   32'h30C, 1, 32'h08, 3'd1, 0);

      // Asynchronous reset mid-cycle
      #2 rst_n32 = 1'b0;
      #1;
      check_eq("mid rst pc", pc32, 32'h0);
      check_eq("mid rst cnt", {29'd0, cnt32}, 32'd0);
      check_eq("mid rst valid", {31'd0, valid32}, 32'd0);
      check_eq("mid rst epc", epc32, 32'h0);
      #2 rst_n32 = 1'b1;
      step(0, R, 32'h0, 32'h0, 1, 32'h0, 3'd0, 0);
      step(0, R, 32'h0, 32'h4, 1, 32'h0, 3'd0, 1);
      // 32-bit wrap
      step(0, B, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 32'h0, 3'd0, 0);
      step(0, N, 32'h0,         32'h0000_0000, 1, 32'h0, 3'd0, 0);

      // 16-bit instance: wrap, then mid-cycle reset discards the stack
      step(1, B, 32'hFFF8, 32'hFFF8, 1, 32'h0, 3'd0, 0);
      step(1, L, 32'h0,    32'hFFFC, 1, 32'h0, 3'd1, 0);
      step(1, N, 32'h0,    32'h0000, 1, 32'h0, 3'd1, 0);
      #2 rst_n16 = 1'b0;
      #1;
      check_eq("w16 mid rst pc", {16'h0000, pc16}, 32'h0100);
      check_eq("w16 mid rst cnt", {29'd0, cnt16}, 32'd0);
      check_eq("w16 mid rst valid", {31'd0, valid16}, 32'd0);
      #2 rst_n16 = 1'b1;
      step(1, R, 32'h0, 32'h0100, 1, 32'h0, 3'd0, 0);
      step(1, R, 32'h0, 32'h0104, 1, 32'h0, 3'd0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
